// File: rtl/nonce_scan.sv
// nonce_scan: streams NUM_NONCES hash words from memory and tracks the first word below target and the minimum hash.
// Optional NONCE_SCAN_WRITEBACK_EN writes the {found, found_nonce, best_hash} record back at result_addr.
module nonce_scan #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NONCE_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        hash_addr,
  input  logic [15:0]        result_addr,
  input  logic [31:0]        target,
  input  logic [31:0]        mem_read_data,
  output logic               done,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [31:0]        best_hash
);

  localparam int unsigned      IDX_W    = $clog2(NUM_NONCES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES);

  typedef enum logic [2:0] {IDLE, SCAN, WB0, WB1, WB2} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rd_idx;
  logic [15:0]        hash_addr_q;
  logic [31:0]        target_q;
  logic               accept;
  logic               scan_last;
  logic               word_valid;
  logic [NONCE_W-1:0] word_nonce;

  assign mem_clk    = clk;
  assign done       = (state == IDLE);
  assign accept     = (state == IDLE) && start;
  assign scan_last  = (state == SCAN) && (rd_idx == LAST_IDX);
  assign word_valid = (state == SCAN) && (rd_idx != '0);
  // Read data lags the address by one cycle, so the word in flight belongs to rd_idx-1.
  assign word_nonce = NONCE_W'(rd_idx - IDX_W'(1));

`ifdef NONCE_SCAN_WRITEBACK_EN
  logic [15:0] result_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_addr_q <= '0;
    end else if (accept) begin
      result_addr_q <= result_addr;
    end
  end
`else
  logic unused_result_addr;

  assign unused_result_addr = ^result_addr;
  assign mem_we             = 1'b0;
  assign mem_write_data     = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
`ifdef NONCE_SCAN_WRITEBACK_EN
    mem_we         = 1'b0;
    mem_write_data = '0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (rd_idx != LAST_IDX) begin
          mem_addr = hash_addr_q + 16'(rd_idx);
        end
        if (scan_last) begin
`ifdef NONCE_SCAN_WRITEBACK_EN
          state_nxt = WB0;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef NONCE_SCAN_WRITEBACK_EN
      WB0: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q;
        mem_write_data = {31'b0, found};
        state_nxt      = WB1;
      end
      WB1: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q + 16'd1;
        mem_write_data = 32'(found_nonce);
        state_nxt      = WB2;
      end
      WB2: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q + 16'd2;
        mem_write_data = best_hash;
        state_nxt      = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx      <= '0;
      hash_addr_q <= '0;
      target_q    <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      best_nonce  <= '0;
      best_hash   <= '1;
    end else if (accept) begin
      rd_idx      <= '0;
      hash_addr_q <= hash_addr;
      target_q    <= target;
      found       <= 1'b0;
      found_nonce <= '0;
      best_nonce  <= '0;
      best_hash   <= '1;
    end else if (state == SCAN) begin
      if (!scan_last) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
      if (word_valid) begin
        if (!found && (mem_read_data < target_q)) begin
          found       <= 1'b1;
          found_nonce <= word_nonce;
        end
        // Strict less-than keeps the earliest nonce when hashes tie.
        if (mem_read_data < best_hash) begin
          best_hash  <= mem_read_data;
          best_nonce <= word_nonce;
        end
      end
    end
  end

endmodule

// File: doc/nonce_scan.md
# nonce_scan

Downstream result stage for the bitcoin hashing engine. After the hasher finishes writing one 32-bit final hash word per nonce into shared memory, this block streams those words back and compares each one against a difficulty target. It reports the lowest winning nonce and the minimum hash seen. Optionally it writes a 3-word result record back to memory.

## Interface
- NUM_NONCES, 16, number of hash words scanned (one per nonce, nonce = word index)
- NONCE_W, 8, width of nonce index outputs; must satisfy 2^NONCE_W ≥ NUM_NONCES
- clk  in  1  clock; mem_clk is driven from it
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin scan; sampled only in IDLE
- hash_addr  in  16  word address of hash word for nonce 0; captured on start
- result_addr  in  16  word address of result record; captured on start
- target  in  32  unsigned difficulty target; captured on start
- mem_read_data  in  32  memory read data, valid one cycle after address
- done  out  1  high while in IDLE
- mem_clk  out  1  equals clk
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory word address
- mem_write_data  out  32  memory write data
- found  out  1  at least one hash < target
- found_nonce  out  NONCE_W  lowest index with hash < target; 0 if none
- best_nonce  out  NONCE_W  index of minimum hash; lowest index on ties
- best_hash  out  32  minimum hash value

## Operation
- States: IDLE → SCAN → (WB0 → WB1 → WB2, when writeback is compiled in) → IDLE.
- IDLE behaviour:
  - done=1, mem_we=0.
  - On start=1: capture hash_addr, result_addr and target.
  - Clear found=0, found_nonce=0, best_nonce=0, best_hash=32'hFFFFFFFF.
  - Clear rd_idx=0 and go to SCAN.
- SCAN is a pipelined read of NUM_NONCES+1 cycles, indexed j = 0..NUM_NONCES:
  - For j < NUM_NONCES: mem_addr = hash_addr_q + j (16-bit wrap), mem_we=0.
  - For j ≥ 1: mem_read_data is word j-1 and is evaluated at the end of that cycle.
- Evaluation of word h at index n:
  - If !found and h < target (unsigned, strict): found ← 1, found_nonce ← n.
  - If h < best_hash (strict): best_hash ← h, best_nonce ← n. Strict comparison gives the lowest-index tie-break.
- After cycle j = NUM_NONCES: go to WB0 if writeback is compiled in, otherwise to IDLE.
- Writeback states (mem_we=1):
  - WB0: mem_addr = result_addr_q, data {31'b0, found}.
  - WB1: mem_addr = result_addr_q+1, data zero-extended found_nonce.
  - WB2: mem_addr = result_addr_q+2, data best_hash.
  - Then IDLE.
- start while not in IDLE is ignored. start held high continuously gives back-to-back scans with one IDLE cycle between them.
- Result outputs hold their values in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, found=0, found_nonce=0, best_nonce=0, best_hash=32'hFFFFFFFF.
- Start accepted at edge E0:
  - done=0 from E0.
  - Final results are valid after edge E0+NUM_NONCES+1.
- Return to IDLE (done=1):
  - Without writeback: after E0+NUM_NONCES+1, i.e. done low for 17 cycles at default.
  - With writeback: after E0+NUM_NONCES+4, i.e. done low for 20 cycles.
- Writes occur on three consecutive clk edges, with no gaps.
- mem_addr and mem_we are registered or decoded from state only; there are no combinational paths from inputs.
- Reset mid-operation: return to IDLE immediately with reset values. No further reads or writes are issued, and any partial results are discarded.
- Address wrap: hash_addr_q+j and result_addr_q+k wrap modulo 2^16.

## Configuration
- NONCE_SCAN_WRITEBACK_EN defined:
  - The WB0–WB2 states exist and the 3-word record is written at result_addr.
  - Latency is NUM_NONCES+4.
- Not defined:
  - There are no WB states; mem_we is constant 0 and mem_write_data is constant 0.
  - result_addr is unused.
  - Latency is NUM_NONCES+1.

## Test plan
- Two hits: words = 32'hF0000000+i except word5=32'h00000800 and word9=32'h00000010; target=32'h00001000 → found=1, found_nonce=5, best_nonce=9, best_hash=32'h00000010, done after 17 cycles.
- No hit: words = 32'hF0000000+i, target=32'h00001000 → found=0, found_nonce=0, best_nonce=0, best_hash=32'hF0000000.
- Tie and strictness: word3=word7=32'h00000020 (others larger), target=32'h00000020 → found=0, best_nonce=3, best_hash=32'h00000020.
- Writeback (macro defined), result_addr=16'h0100, using the first scenario's data → exactly three writes on consecutive edges: 0x0100←1, 0x0101←5, 0x0102←32'h00000010. No writes when the macro is undefined.
- Reset abort: deassert reset_n during SCAN j=8 → done=1, best_hash=32'hFFFFFFFF, no mem_we. Rerun of the first scenario then gives identical results.
- Busy start and wrap: pulse start during SCAN → ignored. hash_addr=16'hFFF8 → reads wrap to 0x0000..0x0007, results correct.
